// File: rtl/posit_encode_pipe.sv
// Three-stage posit encoder: sign/scale/fraction in, N-bit posit out, with
// round-to-nearest-even, saturation to maxpos/minpos and NaR/zero specials.
module posit_encode_pipe #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int SW = 9,
  parameter int FW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_zero,
  input  logic          in_nar,
  input  logic [SW-1:0] in_scale,
  input  logic [FW-1:0] in_frac,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
);
  localparam int KW  = SW - ES;
  localparam int BW  = N + ES + FW;
  localparam int LIM = (N - 2) << ES;

  logic                adv_s;

  logic signed [31:0]  scale_ext_s;
  logic [KW-1:0]       k_s;
  logic [KW:0]         run1_d;
  logic                pos1_d, hi1_d, lo1_d;

  logic                v1_q, sign1_q, nar1_q, zero1_q, hi1_q, lo1_q, pos1_q;
  logic [KW:0]         run1_q;
  logic [ES-1:0]       e1_q;
  logic [FW-1:0]       frac1_q;

  logic [BW-1:0]       tail_s, shv_s;
  logic [N-2:0]        body2_d;
  logic                guard2_d, sticky2_d;

  logic                v2_q, sign2_q, nar2_q, zero2_q, hi2_q, lo2_q;
  logic [N-2:0]        body2_q;
  logic                guard2_q, sticky2_q;

  logic                inc_s;
  logic [N-2:0]        rnd_s, mag_s;
  logic [N-1:0]        posit3_d;

  logic                v3_q;
  logic [N-1:0]        posit_q;

  assign adv_s     = ~v3_q | out_ready;
  assign in_ready  = adv_s;
  assign out_valid = v3_q;
  assign out_posit = posit_q;

  // S1: split scale into regime run length/polarity and exponent; flag out-of-range scales
  always_comb begin
    scale_ext_s = {{(32-SW){in_scale[SW-1]}}, in_scale};
    hi1_d       = (scale_ext_s > LIM);
    lo1_d       = (scale_ext_s < -LIM);
    k_s         = in_scale[SW-1:ES];
    pos1_d      = ~k_s[KW-1];
    if (pos1_d) begin
      run1_d = {1'b0, k_s} + {{KW{1'b0}}, 1'b1};
    end else begin
      run1_d = ~{k_s[KW-1], k_s} + {{KW{1'b0}}, 1'b1};
    end
  end

  // S2: shift the regime run in ahead of {terminator, e, frac}; low zero pad keeps dropped bits for sticky
  always_comb begin
    tail_s = {~pos1_q, e1_q, frac1_q, {(N-1){1'b0}}};
    if (pos1_q) begin
      shv_s = ~((~tail_s) >> run1_q);
    end else begin
      shv_s = tail_s >> run1_q;
    end
    body2_d   = shv_s[BW-1 -: N-1];
    guard2_d  = shv_s[BW-N];
    sticky2_d = |shv_s[BW-N-1:0];
  end

  // S3: RNE increment, clamp to [minpos, maxpos], then specials and sign
  always_comb begin
    inc_s = guard2_q & (body2_q[0] | sticky2_q);
    rnd_s = body2_q + {{(N-2){1'b0}}, inc_s};
    if (hi2_q || (inc_s && (&body2_q))) begin
      mag_s = {(N-1){1'b1}};
    end else if (lo2_q || ~|rnd_s) begin
      mag_s = {{(N-2){1'b0}}, 1'b1};
    end else begin
      mag_s = rnd_s;
    end
    if (nar2_q) begin
      posit3_d = {1'b1, {(N-1){1'b0}}};
    end else if (zero2_q) begin
      posit3_d = {N{1'b0}};
    end else if (sign2_q) begin
      posit3_d = ~{1'b0, mag_s} + {{(N-1){1'b0}}, 1'b1};
    end else begin
      posit3_d = {1'b0, mag_s};
    end
  end

  // Pipeline registers: every stage advances together and holds when the output is stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      posit_q <= {N{1'b0}};
    end else if (adv_s) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (in_valid) begin
        sign1_q <= in_sign;
        nar1_q  <= in_nar;
        zero1_q <= in_zero;
        hi1_q   <= hi1_d;
        lo1_q   <= lo1_d;
        pos1_q  <= pos1_d;
        run1_q  <= run1_d;
        e1_q    <= in_scale[ES-1:0];
        frac1_q <= in_frac;
      end
      if (v1_q) begin
        sign2_q   <= sign1_q;
        nar2_q    <= nar1_q;
        zero2_q   <= zero1_q;
        hi2_q     <= hi1_q;
        lo2_q     <= lo1_q;
        body2_q   <= body2_d;
        guard2_q  <= guard2_d;
        sticky2_q <= sticky2_d;
      end
      if (v2_q) begin
        posit_q <= posit3_d;
      end
    end
  end
endmodule

// File: tb/tb_posit_encode_pipe.sv
// Directed bench for posit_encode_pipe: isolated encodes with latency/hold checks,
// a backpressured stream, and a mid-stream reset.
module tb_posit_encode_pipe;
  localparam int N  = 32;
  localparam int ES = 2;
  localparam int SW = 9;
  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, in_sign, in_zero, in_nar;
  logic          out_valid, out_ready;
  logic [SW-1:0] in_scale;
  logic [FW-1:0] in_frac;
  logic [N-1:0]  out_posit;

  int err_cnt = 0;
  int chk_cnt = 0;

  typedef struct {
    int          scale;
    logic [31:0] frac;
    logic        sign;
    logic        zero;
    logic        nar;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];

  posit_encode_pipe #(.N(N), .ES(ES), .SW(SW), .FW(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_zero(in_zero), .in_nar(in_nar),
    .in_scale(in_scale), .in_frac(in_frac),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add_vec(input int sc, input logic [31:0] fr, input logic sg,
                         input logic zr, input logic nr, input logic [31:0] ex);
    vec_t v;
    v.scale = sc; v.frac = fr; v.sign = sg; v.zero = zr; v.nar = nr; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic drive_vec(input vec_t v);
    logic [31:0] sc;
    sc       = v.scale;
    in_valid = 1'b1;
    in_scale = sc[SW-1:0];
    in_frac  = v.frac;
    in_sign  = v.sign;
    in_zero  = v.zero;
    in_nar   = v.nar;
  endtask

  // Idle cycles carry junk fields that must be ignored.
  task automatic drive_idle();
    in_valid = 1'b0;
    in_scale = {SW{1'b1}};
    in_frac  = 32'hDEADBEEF;
    in_sign  = 1'b1;
    in_zero  = 1'b0;
    in_nar   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    int nacc, nemit;
    localparam int BASE = 6;

    add_vec(0,    32'h00000000, 1'b0, 1'b0, 1'b0, 32'h40000000);
    add_vec(1,    32'h00000000, 1'b0, 1'b0, 1'b0, 32'h48000000);
    add_vec(4,    32'h00000000, 1'b0, 1'b0, 1'b0, 32'h60000000);
    add_vec(-1,   32'h00000000, 1'b0, 1'b0, 1'b0, 32'h38000000);
    add_vec(0,    32'h00000000, 1'b1, 1'b0, 1'b0, 32'hC0000000);
    add_vec(0,    32'h00000010, 1'b0, 1'b0, 1'b0, 32'h40000000);
    add_vec(0,    32'h00000030, 1'b0, 1'b0, 1'b0, 32'h40000002);
    add_vec(0,    32'h00000018, 1'b0, 1'b0, 1'b0, 32'h40000001);
    add_vec(200,  32'h00000000, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF);
    add_vec(-200, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000001);
    add_vec(-200, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);
    add_vec(5,    32'h12345678, 1'b1, 1'b1, 1'b1, 32'h80000000);
    add_vec(7,    32'h12345678, 1'b1, 1'b1, 1'b0, 32'h00000000);
    add_vec(2,    32'h80000000, 1'b0, 1'b0, 1'b0, 32'h54000000);
    add_vec(2,    32'h80000000, 1'b1, 1'b0, 1'b0, 32'hAC000000);
    add_vec(-5,   32'h00000000, 1'b0, 1'b0, 1'b0, 32'h1C000000);
    add_vec(120,  32'h00000000, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF);
    add_vec(-120, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000001);
    add_vec(119,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF);
    add_vec(-118, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000002);
    add_vec(-121, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);
    add_vec(121,  32'h00000000, 1'b1, 1'b0, 1'b0, 32'h80000001);

    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_out_posit", out_posit, 32'd0);
    rst_n = 1'b1;

    // Isolated encodes: latency 3, posit held through the bubble that precedes each result.
    prev = 32'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #1;
      check_val($sformatf("iso%0d_rdy", i), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      check_val($sformatf("iso%0d_early", i), {31'd0, out_valid}, 32'd0);
      check_val($sformatf("iso%0d_hold", i), out_posit, prev);
      @(negedge clk);
      check_val($sformatf("iso%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check_val($sformatf("iso%0d_posit", i), out_posit, vecs[i].exp);
      prev = vecs[i].exp;
    end

    // Backpressured stream of 6 operands, out_ready low in cycles 4..7.
    @(negedge clk);
    nacc  = 0;
    nemit = 0;
    exp_q.delete();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      out_ready = !(t >= 4 && t <= 7);
      if (nacc < 6) drive_vec(vecs[BASE + nacc]);
      else drive_idle();
      #1;
      check_val($sformatf("bp_rdy_t%0d", t), {31'd0, in_ready}, (t >= 4 && t <= 7) ? 32'd0 : 32'd1);
      if (t >= 4 && t <= 7) begin
        check_val($sformatf("bp_stall_valid_t%0d", t), {31'd0, out_valid}, 32'd1);
        check_val($sformatf("bp_stall_posit_t%0d", t), out_posit, vecs[BASE + 1].exp);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(vecs[BASE + nacc].exp);
        nacc++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val($sformatf("bp_extra_t%0d", t), exp_q.size(), 32'd1);
        end else begin
          check_val($sformatf("bp_out%0d", nemit), out_posit, exp_q.pop_front());
        end
        nemit++;
      end
    end
    drive_idle();
    check_val("bp_emitted", nemit, 32'd6);

    // Reset with three operands in flight.
    out_ready = 1'b1;
    @(negedge clk);
    drive_vec(vecs[13]);
    @(negedge clk);
    drive_vec(vecs[14]);
    @(negedge clk);
    drive_vec(vecs[15]);
    out_ready = 1'b0;
    @(negedge clk);
    drive_idle();
    #1;
    check_val("rs_full_valid", {31'd0, out_valid}, 32'd1);
    check_val("rs_full_rdy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("rs_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rs_out_posit", out_posit, 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    drive_vec(vecs[3]);
    #1;
    check_val("rs_rdy", {31'd0, in_ready}, 32'd1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      drive_idle();
      if (c == 3) begin
        check_val("rs_new_valid", {31'd0, out_valid}, 32'd1);
        check_val("rs_new_posit", out_posit, vecs[3].exp);
      end else begin
        check_val($sformatf("rs_quiet_c%0d", c), {31'd0, out_valid}, 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/posit_encode_pipe.md
POSIT_ENCODE_PIPE -- requirements
Module: posit_encode_pipe

Interface
REQ-001 SHALL have parameter N, default 32, posit width in bits.
REQ-002 SHALL have parameter ES, default 2, exponent field width.
REQ-003 SHALL have parameter SW, default 9, signed scale input width.
REQ-004 SHALL have parameter FW, default 32, fraction input width, excluding hidden bit; MSB weight 2^-1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  input operand valid.
REQ-008 in_ready  output  1  block accepts operand this cycle.
REQ-009 in_sign  input  1  sign of value, 1 = negative.
REQ-010 in_zero  input  1  value is zero; overrides scale/fraction.
REQ-011 in_nar  input  1  value is NaR; overrides all other fields.
REQ-012 in_scale  input  SW  signed two's-complement power-of-two scale.
REQ-013 in_frac  input  FW  fraction bits after hidden one.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 out_posit  output  N  encoded posit.

Function
REQ-017 SHALL encode value (-1)^sign * 2^scale * (1.frac) into N-bit posit with ES exponent bits.
REQ-018 SHALL derive k = scale >>> ES (arithmetic) and e = scale[ES-1:0].
REQ-019 Regime SHALL be (k+1) ones then a zero for k >= 0, and (-k) zeros then a one for k < 0; terminating bit omitted when run fills N-1 bits.
REQ-020 Body after sign SHALL be regime, e, frac, truncated to N-1 bits.
REQ-021 Rounding SHALL be round-to-nearest-even on truncated bits: guard = first dropped bit, sticky = OR of remaining dropped bits.
REQ-022 Rounding increment SHALL apply iff guard & (lsb | sticky).
REQ-023 Scale > (N-2)*2^ES SHALL produce maxpos (0x7FFFFFFF for N=32) before sign application; rounding SHALL never exceed maxpos.
REQ-024 Scale < -(N-2)*2^ES SHALL produce minpos (0x00000001); rounding SHALL never produce zero from nonzero input.
REQ-025 Negative results SHALL be two's complement of positive encoding.
REQ-026 in_nar SHALL produce 1 followed by N-1 zeros; in_zero (with in_nar=0) SHALL produce all zeros; sign ignored for both.
REQ-027 Pipeline SHALL be 3 registered stages: S1 decompose/clamp k, e; S2 regime/body barrel shift with guard/sticky; S3 round, saturate, negate.
REQ-028 Latency SHALL be exactly 3 cycles from accepted input to out_valid with no stall.
REQ-029 Throughput SHALL be one operand per cycle when out_ready is held high.
REQ-030 Advance condition SHALL be adv = ~out_valid | out_ready; in_ready SHALL equal adv combinationally.
REQ-031 Input SHALL be accepted iff in_valid & in_ready.
REQ-032 When adv=0, all stage registers, including valid bits, SHALL hold.
REQ-033 out_posit SHALL remain stable while out_valid=1 and out_ready=0.
REQ-034 Bubbles SHALL propagate as valid=0 stages; data in bubble stages is don't-care, but out_posit SHALL be held at its last value.
REQ-035 Fields other than valid SHALL be ignored when in_valid=0.

Reset
REQ-036 rst_n=0 at a rising edge SHALL clear all three stage valid bits; out_valid SHALL be 0 and out_posit 0 on the following cycle.
REQ-037 Operands in flight at reset SHALL be discarded, never emitted.
REQ-038 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-039 Basic encodes, N=32, ES=2, frac=0: scale 0 -> 0x40000000; scale 1 -> 0x48000000; scale 4 -> 0x60000000; scale -1 -> 0x38000000; scale 0 with sign=1 -> 0xC0000000; each appears 3 cycles after acceptance.
REQ-040 Rounding at scale 0: frac 0x00000010 -> 0x40000000 (tie, even); frac 0x00000030 -> 0x40000002 (tie, odd up); frac 0x00000018 -> 0x40000001 (sticky up).
REQ-041 Saturation and specials: scale 200 -> 0x7FFFFFFF; scale -200 -> 0x00000001; scale -200 with sign=1 -> 0xFFFFFFFF; in_nar -> 0x80000000; in_zero -> 0x00000000.
REQ-042 Backpressure: stream 6 operands with out_ready low for cycles 4-7 -> in_ready=0 while pipe full; no loss, duplication or reordering; out_posit stable while stalled.
REQ-043 Reset mid-stream: assert rst_n=0 with 3 operands in flight -> out_valid=0 next cycle; none of those operands ever emitted; first post-reset operand emitted after exactly 3 cycles.
